memory_bus_responder: RTL and testbench



---
 rtl/memory_bus_responder_pkg.sv | 40 ++++
 rtl/memory_bus_responder_memory_array.sv | 23 ++
 rtl/memory_bus_responder.sv | 137 +++++++++++++
 tb/tb_memory_bus_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_responder_pkg.sv
// Shared memory-bus types: packet layout, command encoding and packet builder.
package memory_bus_responder_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned CMD_W     = 2;

    typedef logic [ID_W-1:0]      BusID;
    typedef logic [ADDR_W-1:0]    memory_address_t;
    typedef logic [PAYLOAD_W-1:0] bus_packet_payload_t;

    typedef enum logic [CMD_W-1:0] {
        bus_read_data     = 2'd0,
        bus_write_data    = 2'd1,
        bus_read_response = 2'd2
    } bus_cmd_t;

    typedef struct packed {
        bus_cmd_t            command;
        BusID                source;
        memory_address_t     address;
        bus_packet_payload_t payload;
    } BusPacket;

    function automatic BusPacket create_bus_packet(
        input bus_cmd_t            command,
        input BusID                source,
        input memory_address_t     address,
        input bus_packet_payload_t payload
    );
        BusPacket p;
        p.command = command;
        p.source  = source;
        p.address = address;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/memory_bus_responder_memory_array.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module memory_bus_responder_memory_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_bus_responder.sv
// Memory-bus slave: accepts one request at a time, services it against the
// internal array after a fixed latency and posts read responses.
module memory_bus_responder
    import memory_bus_responder_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ACCESS_LATENCY = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     req_busy,
    input  BusPacket req_packet,
    output logic     req_accept,
    input  logic     rsp_busy,
    output BusPacket rsp_packet,
    output logic     rsp_send,
    output logic     bad_cmd
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    bus_cmd_t            held_cmd;
    BusID                held_src;
    logic [IDX_W-1:0]    held_idx;
    bus_packet_payload_t held_payload;
    bus_packet_payload_t rd_word;
    bus_packet_payload_t mem_rdata;

    logic             accept_c, finish_c, send_c, mem_we_c;
    logic [IDX_W-1:0] mem_addr_c;
    logic             unused_addr_bits;

    // Upper address bits are deliberately ignored (index wraps modulo DEPTH).
    assign unused_addr_bits = ^req_packet.address[ADDR_W-1:IDX_W];

    memory_bus_responder_memory_array #(
        .DEPTH (DEPTH),
        .WIDTH (PAYLOAD_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_c),
        .addr  (mem_addr_c),
        .wdata (held_payload),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM address comes from the live request in IDLE so read data is ready
    // on the first ACCESS cycle even when ACCESS_LATENCY is 1.
    always_comb begin
        state_nxt  = state;
        accept_c   = 1'b0;
        finish_c   = 1'b0;
        send_c     = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr_c = held_idx;
        case (state)
            IDLE: begin
                mem_addr_c = req_packet.address[IDX_W-1:0];
                if (req_busy) begin
                    accept_c  = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    finish_c = 1'b1;
                    case (held_cmd)
                        bus_write_data: begin
                            mem_we_c  = !reset;
                            state_nxt = IDLE;
                        end
                        bus_read_data: state_nxt = RESPOND;
                        default:       state_nxt = IDLE;
                    endcase
                end
            end
            RESPOND: begin
                if (!rsp_busy) begin
                    send_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            held_cmd     <= bus_read_data;
            held_src     <= '0;
            held_idx     <= '0;
            held_payload <= '0;
            rd_word      <= '0;
            req_accept   <= 1'b0;
            rsp_send     <= 1'b0;
            rsp_packet   <= '0;
            bad_cmd      <= 1'b0;
        end else begin
            req_accept <= accept_c;
            rsp_send   <= send_c;
            if (accept_c) begin
                held_cmd     <= req_packet.command;
                held_src     <= req_packet.source;
                held_idx     <= req_packet.address[IDX_W-1:0];
                held_payload <= req_packet.payload;
                cnt          <= CNT_W'(ACCESS_LATENCY - 1);
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (finish_c && held_cmd == bus_read_data) begin
                rd_word <= mem_rdata;
            end
            if (finish_c && held_cmd != bus_read_data && held_cmd != bus_write_data) begin
                bad_cmd <= 1'b1;
            end
            if (send_c) begin
                rsp_packet <= create_bus_packet(bus_read_response, held_src, '0, rd_word);
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_responder.sv
// Randomized scoreboard bench for memory_bus_responder with a word-array model.
module tb_memory_bus_responder;
    import memory_bus_responder_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned NPOOL = 16;

    logic     clk;
    logic     reset;
    logic     req_busy;
    BusPacket req_packet;
    logic     req_accept;
    logic     rsp_busy;
    BusPacket rsp_packet;
    logic     rsp_send;
    logic     bad_cmd;

    memory_bus_responder #(.DEPTH(DEPTH), .ACCESS_LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_busy   (req_busy),
        .req_packet (req_packet),
        .req_accept (req_accept),
        .rsp_busy   (rsp_busy),
        .rsp_packet (rsp_packet),
        .rsp_send   (rsp_send),
        .bad_cmd    (bad_cmd)
    );

    typedef struct {
        BusPacket pkt;
        bit       rel;
    } exp_t;

    exp_t                q[$];
    bus_packet_payload_t model[DEPTH];
    BusPacket            last_pkt;
    int                  vectors;
    int                  miscompares;
    int                  cyc;
    int                  accept_cyc;
    int                  release_cyc;
    int                  accepts;
    int                  sends;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every rsp_send.
    always @(negedge clk) begin
        exp_t e;
        if (req_accept) begin
            accept_cyc = cyc;
            accepts++;
            check("one_outstanding", 128'(q.size() <= 1), 128'(1));
        end
        if (rsp_send) begin
            sends++;
            if (q.size() == 0) begin
                check("unexpected_rsp", 128'(1), 128'(0));
            end else begin
                e = q.pop_front();
                check("rsp_packet", 128'(rsp_packet), 128'(e.pkt));
                check("rsp_latency", 128'(cyc),
                      128'(e.rel ? release_cyc + 1 : accept_cyc + int'(LAT) + 1));
                last_pkt = e.pkt;
            end
        end
    end

    // Post one request, wait for its accept, then update the reference model.
    task automatic do_req(input bus_cmd_t cmd, input BusID src, input memory_address_t addr,
                          input bus_packet_payload_t pl, input bit keep, input bit rel,
                          input bit abort);
        bit   got;
        int   idx;
        exp_t e;
        got = 1'b0;
        @(negedge clk);
        req_packet.command = cmd;
        req_packet.source  = src;
        req_packet.address = addr;
        req_packet.payload = pl;
        req_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (req_accept) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_seen", 128'(got), 128'(1));
        if (!keep) req_busy = 1'b0;
        idx = int'(addr % DEPTH);
        if (got && !abort) begin
            if (cmd == bus_write_data) begin
                model[idx] = pl;
            end else if (cmd == bus_read_data) begin
                e.pkt.command = bus_read_response;
                e.pkt.source  = src;
                e.pkt.address = '0;
                e.pkt.payload = model[idx];
                e.rel = rel;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        check(name, 128'(q.size()), 128'(0));
    endtask

    initial begin
        int a0, s0;
        int unsigned pool[NPOOL];
        vectors = 0; miscompares = 0; cyc = 0; accept_cyc = 0; release_cyc = 0;
        accepts = 0; sends = 0; last_pkt = '0;
        reset = 1'b1; req_busy = 1'b0; req_packet = '0; rsp_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_accept", 128'(req_accept), 128'(0));
        check("reset_rsp_send",   128'(rsp_send),   128'(0));
        check("reset_rsp_packet", 128'(rsp_packet), 128'(0));
        check("reset_bad_cmd",    128'(bad_cmd),    128'(0));
        reset = 1'b0;

        // Basic write then read-back.
        do_req(bus_write_data, 4'd2, 32'd5, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        do_req(bus_read_data,  4'd3, 32'd5, 32'h0,    1'b0, 1'b0, 1'b0);
        drain("drain_basic");

        // Response channel busy: no send and stable packet until it frees.
        rsp_busy = 1'b1;
        do_req(bus_read_data, 4'd6, 32'd5, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < int'(LAT) + 4; i++) begin
            @(negedge clk);
            check("busy_no_send", 128'(rsp_send),   128'(0));
            check("busy_stable",  128'(rsp_packet), 128'(last_pkt));
        end
        rsp_busy = 1'b0;
        release_cyc = cyc;
        drain("drain_busy");

        // Index wrap-around.
        do_req(bus_write_data, 4'd1, 32'(DEPTH + 7), 32'h1234, 1'b0, 1'b0, 1'b0);
        do_req(bus_read_data,  4'd4, 32'd7,          32'h0,    1'b0, 1'b0, 1'b0);
        do_req(bus_write_data, 4'd1, 32'd9,          32'h0,    1'b0, 1'b0, 1'b0);
        drain("drain_wrap");

        // Non-request command sets a sticky flag.
        do_req(bus_read_response, 4'd5, 32'd3, 32'h55, 1'b0, 1'b0, 1'b0);
        repeat (LAT + 2) @(negedge clk);
        check("bad_cmd_set", 128'(bad_cmd), 128'(1));
        do_req(bus_read_data, 4'd8, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0);
        drain("drain_bad");
        check("bad_cmd_sticky", 128'(bad_cmd), 128'(1));

        // Reset during ACCESS of a write: dropped, not committed.
        do_req(bus_write_data, 4'd1, 32'd9, 32'hBEEF, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_bad_cmd_clr", 128'(bad_cmd), 128'(0));
        check("rst_no_accept",   128'(req_accept), 128'(0));
        reset = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        do_req(bus_read_data, 4'd9, 32'd9, 32'h0, 1'b0, 1'b0, 1'b0);
        drain("drain_rst");

        // Ten back-to-back reads with req_busy held high.
        a0 = accepts; s0 = sends;
        for (int i = 0; i < 10; i++)
            do_req(bus_read_data, BusID'(i + 3), memory_address_t'(i % 2 == 0 ? 5 : 7),
                   32'h0, 1'b1, 1'b0, 1'b0);
        req_busy = 1'b0;
        drain("drain_b2b");
        check("b2b_accepts", 128'(accepts - a0), 128'(10));
        check("b2b_sends",   128'(sends - s0),   128'(10));

        // Randomized traffic over a pool of indices with random upper address bits.
        for (int i = 0; i < int'(NPOOL); i++) begin
            pool[i] = $urandom_range(0, DEPTH - 1);
            do_req(bus_write_data, BusID'($urandom_range(0, 15)), memory_address_t'(pool[i]),
                   $urandom, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            int unsigned k;
            memory_address_t ad;
            k  = $urandom_range(0, NPOOL - 1);
            ad = memory_address_t'(pool[k] + DEPTH * $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                do_req(bus_write_data, BusID'($urandom_range(0, 15)), ad, $urandom,
                       1'b0, 1'b0, 1'b0);
            else
                do_req(bus_read_data, BusID'($urandom_range(0, 15)), ad, 32'h0,
                       1'b0, 1'b0, 1'b0);
        end
        drain("drain_rand");
        check("final_bad_cmd", 128'(bad_cmd), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
